// File: rtl/spi_feed_pkg.sv
// Shared types and helpers for the SPI sample feeder.
package spi_feed_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } feed_state_t;

  localparam int CNT_W = 16;

  // Bits needed to index 'depth' entries (at least 1).
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO; head word read straight from storage, no fall-through.
module sync_fifo
  import spi_feed_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push_in,
  input  logic [DATA_WIDTH-1:0] din_in,
  input  logic                  pop_in,
  output logic [DATA_WIDTH-1:0] dout_out,
  output logic                  full_out,
  output logic                  empty_out
);
  localparam int AW = ptr_w(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
  logic                  push_ok, pop_ok;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty_out = (wr_q == rd_q);
  assign full_out  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_out  = mem_q[rd_q[AW-1:0]];

  assign push_ok = push_in && !full_out;
  assign pop_ok  = pop_in && !empty_out;
  assign wr_d    = push_ok ? wr_q + PTR_ONE : wr_q;
  assign rd_d    = pop_ok  ? rd_q + PTR_ONE : rd_q;

  // Pointer registers; reset empties the buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_in;
  end

endmodule

// File: rtl/spi_sample_feeder.sv
// Paces buffered samples to the SPI DAC transmitter: one launch per sample tick.
module spi_sample_feeder
  import spi_feed_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int FIFO_DEPTH    = 8,
  parameter int SAMPLE_PERIOD = 2268,
  parameter int START_TIMEOUT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  input  logic                  tx_cs_in,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_trigger_out,
  output logic [CNT_W-1:0]      underrun_count_out,
  output logic [CNT_W-1:0]      overrun_count_out,
  output logic                  start_err_out
);
  localparam int TW = ptr_w(SAMPLE_PERIOD);
  localparam int OW = ptr_w(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(START_TIMEOUT);

  feed_state_t           state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [OW-1:0]         to_q, to_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      und_q, und_d, ovr_q, ovr_d;
  logic                  trig_q, err_q, err_d;
  logic                  tick, pop, und_inc, ovr_inc;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (sample_valid_in),
    .din_in    (sample_in),
    .pop_in    (pop),
    .dout_out  (fifo_dout),
    .full_out  (fifo_full),
    .empty_out (fifo_empty)
  );

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // Launch FSM next-state: pop or repeat on tick, then track the transmitter's CS.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    to_d    = to_q;
    err_d   = err_q;
    pop     = 1'b0;
    und_inc = 1'b0;
    ovr_inc = tick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        to_d = '0;
        if (tick) begin
          state_d = LAUNCH;
          if (!fifo_empty) begin
            pop    = 1'b1;
            data_d = fifo_dout;
          end else begin
            und_inc = 1'b1;
          end
        end
      end
      LAUNCH: begin
        to_d    = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!tx_cs_in) begin
          state_d = WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + OW'(1);
        end
      end
      WAIT_DONE: if (tx_cs_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Saturating event counters.
  assign und_d = (und_inc && und_q != '1) ? und_q + CNT_W'(1) : und_q;
  assign ovr_d = (ovr_inc && ovr_q != '1) ? ovr_q + CNT_W'(1) : ovr_q;

  // State, data and counter registers; trigger follows LAUNCH by one cycle so data leads it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      to_q       <= '0;
      data_q     <= '0;
      und_q      <= '0;
      ovr_q      <= '0;
      trig_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      to_q       <= to_d;
      data_q     <= data_d;
      und_q      <= und_d;
      ovr_q      <= ovr_d;
      trig_q     <= (state_q == LAUNCH);
      err_q      <= err_d;
    end
  end

  assign sample_ready_out   = !fifo_full;
  assign tx_data_out        = data_q;
  assign tx_trigger_out     = trig_q;
  assign underrun_count_out = und_q;
  assign overrun_count_out  = ovr_q;
  assign start_err_out      = err_q;

endmodule

// File: tb/tb_spi_sample_feeder.sv
// Directed bench for spi_sample_feeder with a simple transmitter CS model.
module tb_spi_sample_feeder;
  localparam int DW  = 12;
  localparam int SP  = 64;
  localparam int STO = 4;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid_in = 1'b0;
  logic          sample_ready_out;
  logic          tx_cs_in;
  logic [DW-1:0] tx_data_out;
  logic          tx_trigger_out;
  logic [15:0]   underrun_count_out, overrun_count_out;
  logic          start_err_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int tx_mode = 0;   // 0: short busy, 1: busy longer than a sample period, 2: CS stuck high
  int busy;
  int base;
  int trig_cyc[$];
  logic [DW-1:0] trig_dat[$];

  spi_sample_feeder #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (8),
    .SAMPLE_PERIOD (SP),
    .START_TIMEOUT (STO)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .sample_in          (sample_in),
    .sample_valid_in    (sample_valid_in),
    .sample_ready_out   (sample_ready_out),
    .tx_cs_in           (tx_cs_in),
    .tx_data_out        (tx_data_out),
    .tx_trigger_out     (tx_trigger_out),
    .underrun_count_out (underrun_count_out),
    .overrun_count_out  (overrun_count_out),
    .start_err_out      (start_err_out)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT tick counter value.
  always @(posedge clk) begin
    if (rst_in) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Transmitter: drop CS after a trigger, hold it for the busy time.
  always @(negedge clk) begin
    if (rst_in) begin
      tx_cs_in <= 1'b1;
      busy     <= 0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) tx_cs_in <= 1'b1;
    end else if (tx_trigger_out && tx_mode != 2) begin
      tx_cs_in <= 1'b0;
      busy     <= (tx_mode == 1) ? SP + 20 : 20;
    end
  end

  // Log every cycle the trigger is high, with the word presented.
  always @(negedge clk) begin
    if (!rst_in && tx_trigger_out) begin
      trig_cyc.push_back(cyc);
      trig_dat.push_back(tx_data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_data"},  32'(tx_data_out), 32'h0);
    chk({t, "_trig"},  32'(tx_trigger_out), 32'h0);
    chk({t, "_und"},   32'(underrun_count_out), 32'h0);
    chk({t, "_ovr"},   32'(overrun_count_out), 32'h0);
    chk({t, "_err"},   32'(start_err_out), 32'h0);
    chk({t, "_ready"}, 32'(sample_ready_out), 32'h1);
  endtask

  // Hold reset 3 cycles, release, check outputs in the first cycle after reset.
  task automatic apply_reset(input string t);
    @(negedge clk);
    rst_in = 1'b1;
    sample_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    base = trig_cyc.size();
    #1;
    chk_reset(t);
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w, input string tag);
    int g = 0;
    sample_in = w;
    sample_valid_in = 1'b1;
    while (!sample_ready_out && g < 4 * SP) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 32'(sample_ready_out), 32'h1);
    @(negedge clk);
    sample_valid_in = 1'b0;
  endtask

  task automatic chk_trig(input int k, input int exp_cyc, input logic [DW-1:0] exp_dat, input string t);
    chk({t, "_cyc"}, 32'(trig_cyc[base + k]), 32'(exp_cyc));
    chk({t, "_dat"}, 32'(trig_dat[base + k]), 32'(exp_dat));
  endtask

  // Tick cycles are k*SP-1; data updates the next cycle, trigger the cycle after: k*SP+1.
  initial begin
    logic [DW-1:0] w1 [3];
    w1[0] = 12'hABC; w1[1] = 12'h123; w1[2] = 12'hFFF;

    // 1: three words, three launches SP apart, one trigger cycle each
    tx_mode = 0;
    apply_reset("t1_rst");
    for (int i = 0; i < 3; i++) push_word(w1[i], $sformatf("t1_push%0d", i));
    wait_cyc(3 * SP + 5);
    chk("t1_ntrig", 32'(trig_cyc.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) chk_trig(i, (i + 1) * SP + 1, w1[i], $sformatf("t1_l%0d", i));
    chk("t1_und", 32'(underrun_count_out), 32'd0);
    chk("t1_ovr", 32'(overrun_count_out), 32'd0);

    // 2: empty FIFO, two ticks repeat word 0
    apply_reset("t2_rst");
    wait_cyc(2 * SP + 5);
    chk("t2_ntrig", 32'(trig_cyc.size() - base), 32'd2);
    chk_trig(0, SP + 1, 12'h000, "t2_l0");
    chk_trig(1, 2 * SP + 1, 12'h000, "t2_l1");
    chk("t2_und", 32'(underrun_count_out), 32'd2);

    // 3: ten words into an eight-entry FIFO; stalls then drains in order
    apply_reset("t3_rst");
    for (int i = 0; i < 8; i++) push_word(12'(12'h300 + i), $sformatf("t3_push%0d", i));
    chk("t3_full_ready", 32'(sample_ready_out), 32'd0);
    for (int i = 8; i < 10; i++) push_word(12'(12'h300 + i), $sformatf("t3_push%0d", i));
    wait_cyc(10 * SP + 5);
    chk("t3_ntrig", 32'(trig_cyc.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) chk_trig(i, (i + 1) * SP + 1, 12'(12'h300 + i), $sformatf("t3_l%0d", i));
    chk("t3_und", 32'(underrun_count_out), 32'd0);

    // 4: CS held low past the next tick -> one overrun, next launch on the tick after CS rises
    tx_mode = 1;
    apply_reset("t4_rst");
    push_word(12'h111, "t4_push0");
    push_word(12'h222, "t4_push1");
    wait_cyc(3 * SP + 5);
    chk("t4_ntrig", 32'(trig_cyc.size() - base), 32'd2);
    chk_trig(0, SP + 1, 12'h111, "t4_l0");
    chk_trig(1, 3 * SP + 1, 12'h222, "t4_l1");
    chk("t4_ovr", 32'(overrun_count_out), 32'd1);
    chk("t4_und", 32'(underrun_count_out), 32'd0);

    // 5: CS never falls -> error after STO cycles following the trigger, FSM idle again
    tx_mode = 2;
    apply_reset("t5_rst");
    push_word(12'h5A5, "t5_push0");
    wait_cyc(SP + 1 + STO);
    chk("t5_err_before", 32'(start_err_out), 32'd0);
    wait_cyc(SP + 2 + STO);
    chk("t5_err_set", 32'(start_err_out), 32'd1);
    wait_cyc(2 * SP + 5);
    chk("t5_ntrig", 32'(trig_cyc.size() - base), 32'd2);
    chk_trig(1, 2 * SP + 1, 12'h5A5, "t5_l1");
    chk("t5_und", 32'(underrun_count_out), 32'd1);
    chk("t5_ovr", 32'(overrun_count_out), 32'd0);
    chk("t5_err_sticky", 32'(start_err_out), 32'd1);

    // 6: reset during WAIT_DONE with four words queued
    tx_mode = 0;
    apply_reset("t6_rst");
    for (int i = 0; i < 5; i++) push_word(12'(12'h700 + i), $sformatf("t6_push%0d", i));
    wait_cyc(SP + 6);
    chk("t6_ntrig", 32'(trig_cyc.size() - base), 32'd1);
    rst_in = 1'b1;
    @(negedge clk);
    chk_reset("t6_mid");
    rst_in = 1'b0;
    base = trig_cyc.size();
    wait_cyc(SP + 5);
    chk("t6_ntrig_after", 32'(trig_cyc.size() - base), 32'd1);
    chk_trig(0, SP + 1, 12'h000, "t6_l0");
    chk("t6_und", 32'(underrun_count_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
